// File: rtl/vrf_pkg.sv
// Shared types for the masked vector register file: default vector shape and clear-engine states.
package vrf_pkg;
  localparam int LANES_DEF = 16;
  localparam int EW_DEF    = 16;

  typedef logic [LANES_DEF-1:0][EW_DEF-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;
endpackage

// File: rtl/vector_rf_masked_if.sv
// Issue-side bundle of the vector register file: three read ports, masked write, reserve, bulk clear.
interface vector_rf_masked_if
  import vrf_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int EW    = EW_DEF,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]             rs1, rs2, rs3;
  logic [LANES-1:0][EW-1:0]  rd1, rd2, rd3;
  logic                      busy1, busy2, busy3;
  logic                      we;
  logic [AW-1:0]             wa;
  logic [LANES-1:0][EW-1:0]  wd;
  logic [LANES-1:0]          wmask;
  logic                      rsv_valid;
  logic [AW-1:0]             rsv_addr;
  logic                      clr_req;
  logic                      clr_busy;
  logic                      clr_done;

  modport master (
    output rs1, rs2, rs3, we, wa, wd, wmask, rsv_valid, rsv_addr, clr_req,
    input  rd1, rd2, rd3, busy1, busy2, busy3, clr_busy, clr_done
  );

  modport slave (
    input  rs1, rs2, rs3, we, wa, wd, wmask, rsv_valid, rsv_addr, clr_req,
    output rd1, rd2, rd3, busy1, busy2, busy3, clr_busy, clr_done
  );
endinterface

// File: rtl/vrf_read_port.sv
// One combinational read port: stored-data select, per-lane write bypass, zero register, busy flag.
module vrf_read_port
  import vrf_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int EW        = EW_DEF,
  parameter int NREGS     = 32,
  parameter bit REG0_ZERO = 1'b0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic [LANES-1:0][EW-1:0] mem [NREGS],
  input  logic [NREGS-1:0]         pending,
  input  logic                     idle,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [LANES-1:0][EW-1:0] wd,
  input  logic [LANES-1:0]         wmask,
  input  logic [AW-1:0]            rs,
  output logic [LANES-1:0][EW-1:0] rd,
  output logic                     busy
);
  logic hit;

  always_comb begin
    hit = idle && we && (wa == rs);
    rd  = mem[rs];
    for (int i = 0; i < LANES; i++) begin
      if (hit && wmask[i]) rd[i] = wd[i];
    end
    // An in-flight write satisfies the reader, so it is not reported busy.
    busy = pending[rs] && !hit;
    if (REG0_ZERO && (rs == '0)) begin
      rd   = '0;
      busy = 1'b0;
    end
  end
endmodule

// File: rtl/vector_rf_masked.sv
// Vector register file with masked writes, pending-write scoreboard and a one-register-per-cycle clear engine.
module vector_rf_masked
  import vrf_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int EW        = EW_DEF,
  parameter int NREGS     = 32,
  parameter bit REG0_ZERO = 1'b0
) (
  input logic               clk,
  input logic               rst,
  vector_rf_masked_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [LANES-1:0][EW-1:0] mem [NREGS];
  logic [NREGS-1:0]         pending;
  clr_state_e               state, state_nxt;
  logic [AW:0]              idx;
  logic                     idle, in_clear, last_idx, wr_ok, rsv_ok;

  assign idle     = (state == IDLE);
  assign in_clear = (state == CLEAR);
  assign last_idx = (idx == (AW+1)'(NREGS-1));
  assign wr_ok    = idle && bus.we && !(REG0_ZERO && (bus.wa == '0));
  assign rsv_ok   = idle && bus.rsv_valid && !(REG0_ZERO && (bus.rsv_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_req) state_nxt = CLEAR;
      CLEAR:   if (last_idx)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.clr_busy = (state == CLEAR);
    bus.clr_done = (state == DONE);
  end

  // One bit wider than the address so the last index never aliases register 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      idx <= '0;
    else if (idle && bus.clr_req) idx <= '0;
    else if (in_clear)            idx <= idx + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (in_clear) begin
      mem[idx[AW-1:0]] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wmask[i]) mem[bus.wa][i] <= bus.wd[i];
      end
    end
  end

  // Reserve is applied after release so a same-register collision leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (in_clear) begin
      pending[idx[AW-1:0]] <= 1'b0;
    end else if (idle) begin
      if (bus.we) pending[bus.wa]       <= 1'b0;
      if (rsv_ok) pending[bus.rsv_addr] <= 1'b1;
    end
  end

  vrf_read_port #(.LANES(LANES), .EW(EW), .NREGS(NREGS), .REG0_ZERO(REG0_ZERO)) u_rp1 (
    .mem(mem), .pending(pending), .idle(idle), .we(bus.we), .wa(bus.wa),
    .wd(bus.wd), .wmask(bus.wmask), .rs(bus.rs1), .rd(bus.rd1), .busy(bus.busy1)
  );

  vrf_read_port #(.LANES(LANES), .EW(EW), .NREGS(NREGS), .REG0_ZERO(REG0_ZERO)) u_rp2 (
    .mem(mem), .pending(pending), .idle(idle), .we(bus.we), .wa(bus.wa),
    .wd(bus.wd), .wmask(bus.wmask), .rs(bus.rs2), .rd(bus.rd2), .busy(bus.busy2)
  );

  vrf_read_port #(.LANES(LANES), .EW(EW), .NREGS(NREGS), .REG0_ZERO(REG0_ZERO)) u_rp3 (
    .mem(mem), .pending(pending), .idle(idle), .we(bus.we), .wa(bus.wa),
    .wd(bus.wd), .wmask(bus.wmask), .rs(bus.rs3), .rd(bus.rd3), .busy(bus.busy3)
  );
endmodule

// File: tb/tb_vector_rf_masked.sv
// Directed and random checks of vector_rf_masked (REG0_ZERO=1) against an array-based reference model.
module tb_vector_rf_masked;
  import vrf_pkg::*;

  localparam int NR = 32;

  logic clk;
  logic rst;

  vector_rf_masked_if #(.LANES(LANES_DEF), .EW(EW_DEF), .NREGS(NR)) bus ();

  vector_rf_masked #(.LANES(LANES_DEF), .EW(EW_DEF), .NREGS(NR), .REG0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents, pending flags, clears still to do, done phase.
  vec_t mreg [NR];
  bit   mpend [NR];
  int   m_left;
  int   m_idx;
  bit   m_done;

  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t fill(input logic [15:0] x);
    vec_t v;
    for (int i = 0; i < LANES_DEF; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES_DEF; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  function automatic bit m_idle();
    return (m_left == 0) && !m_done;
  endfunction

  function automatic vec_t exp_rd(input logic [4:0] rs);
    vec_t v;
    v = mreg[rs];
    if (m_idle() && bus.we && bus.wa == rs)
      for (int i = 0; i < LANES_DEF; i++) if (bus.wmask[i]) v[i] = bus.wd[i];
    if (rs == 0) v = '0;
    return v;
  endfunction

  function automatic bit exp_busy(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    return mpend[rs] && !(m_idle() && bus.we && bus.wa == rs);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mreg[r]  = '0;
      mpend[r] = 1'b0;
    end
    m_left = 0;
    m_idx  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      mreg[m_idx]  = '0;
      mpend[m_idx] = 1'b0;
      m_idx++;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else begin
      if (bus.we) begin
        if (bus.wa != 0)
          for (int i = 0; i < LANES_DEF; i++) if (bus.wmask[i]) mreg[bus.wa][i] = bus.wd[i];
        mpend[bus.wa] = 1'b0;
      end
      if (bus.rsv_valid && bus.rsv_addr != 0) mpend[bus.rsv_addr] = 1'b1;
      if (bus.clr_req) begin
        m_left = NR;
        m_idx  = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("rd1", bus.rd1, exp_rd(bus.rs1));
    chk("rd2", bus.rd2, exp_rd(bus.rs2));
    chk("rd3", bus.rd3, exp_rd(bus.rs3));
    chk("busy1", bus.busy1, exp_busy(bus.rs1));
    chk("busy2", bus.busy2, exp_busy(bus.rs2));
    chk("busy3", bus.busy3, exp_busy(bus.rs3));
    chk("clr_busy", bus.clr_busy, m_left > 0);
    chk("clr_done", bus.clr_done, m_done);
  endtask

  // Called at a negedge with inputs stable: check, then clock the DUT and model together.
  task automatic tick();
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    tick();
  endtask

  task automatic set_idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.rs3 = '0;
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.wmask = '0;
    bus.rsv_valid = 1'b0; bus.rsv_addr = '0; bus.clr_req = 1'b0;
  endtask

  initial begin
    vec_t e;
    int busy_cnt, done_cnt, done_at;
    n_assert = 0;
    n_fail   = 0;
    set_idle();
    rst = 1'b1;
    model_reset();
    #12;
    chk("reset_rd1", bus.rd1, '0);
    chk("reset_busy1", bus.busy1, 1'b0);
    chk("reset_clr_busy", bus.clr_busy, 1'b0);
    chk("reset_clr_done", bus.clr_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full write of r5, read back next cycle.
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = fill(16'h1234); bus.wmask = 16'hFFFF;
    cyc();
    set_idle(); bus.rs1 = 5'd5;
    @(negedge clk);
    chk("wr_full_rd1", bus.rd1, fill(16'h1234));
    chk("wr_full_busy1", bus.busy1, 1'b0);
    tick();

    // Masked write with same-cycle read.
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = fill(16'hABCD); bus.wmask = 16'h00F0; bus.rs2 = 5'd5;
    for (int i = 0; i < LANES_DEF; i++) e[i] = (i >= 4 && i <= 7) ? 16'hABCD : 16'h1234;
    @(negedge clk);
    chk("mask_bypass_rd2", bus.rd2, e);
    tick();
    set_idle(); bus.rs2 = 5'd5;
    @(negedge clk);
    chk("mask_after_rd2", bus.rd2, e);
    tick();

    // Scoreboard: reserve, release with empty mask, simultaneous reserve+release.
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
    cyc();
    set_idle(); bus.rs3 = 5'd7;
    @(negedge clk);
    chk("rsv_busy3", bus.busy3, 1'b1);
    tick();
    bus.we = 1'b1; bus.wa = 5'd7; bus.wmask = 16'h0000; bus.wd = rand_vec(); bus.rs3 = 5'd7;
    @(negedge clk);
    chk("release_bypass_busy3", bus.busy3, 1'b0);
    tick();
    set_idle(); bus.rs3 = 5'd7;
    @(negedge clk);
    chk("release_after_busy3", bus.busy3, 1'b0);
    tick();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    bus.we = 1'b1; bus.wa = 5'd9; bus.wmask = 16'hFFFF; bus.wd = rand_vec();
    cyc();
    set_idle(); bus.rs1 = 5'd9;
    @(negedge clk);
    chk("set_wins_busy1", bus.busy1, 1'b1);
    tick();

    // Register 0 is hard zero and never pending.
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = fill(16'hFFFF); bus.wmask = 16'hFFFF;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0; bus.rs1 = 5'd0;
    @(negedge clk);
    chk("r0_bypass_rd1", bus.rd1, '0);
    chk("r0_bypass_busy1", bus.busy1, 1'b0);
    tick();
    set_idle(); bus.rs1 = 5'd0;
    @(negedge clk);
    chk("r0_after_rd1", bus.rd1, '0);
    chk("r0_after_busy1", bus.busy1, 1'b0);
    tick();

    // Fill every register, then bulk clear with a write attempted mid-clear.
    for (int r = 0; r < NR; r++) begin
      set_idle();
      bus.we = 1'b1; bus.wa = 5'(r); bus.wmask = 16'hFFFF;
      bus.wd = rand_vec(); bus.wd[0][0] = 1'b1;
      bus.rsv_valid = r[0]; bus.rsv_addr = 5'(r + 3);
      bus.rs1 = 5'(r - 1); bus.rs2 = 5'(r); bus.rs3 = 5'(r + 3);
      cyc();
    end
    set_idle(); bus.clr_req = 1'b1;
    cyc();
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      set_idle();
      if (k == 5) begin
        bus.we = 1'b1; bus.wa = 5'd12; bus.wd = rand_vec(); bus.wmask = 16'hFFFF;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd13; bus.clr_req = 1'b1;
      end
      bus.rs1 = 5'(k); bus.rs2 = 5'd12; bus.rs3 = 5'd31;
      @(negedge clk);
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) begin
        done_cnt++;
        done_at = k;
      end
      tick();
    end
    chk("clr_busy_cycles", 256'(busy_cnt), 256'd32);
    chk("clr_done_pulses", 256'(done_cnt), 256'd1);
    chk("clr_done_cycle", 256'(done_at), 256'd33);
    for (int r = 0; r < NR; r++) begin
      set_idle(); bus.rs1 = 5'(r); bus.rs2 = 5'(r); bus.rs3 = 5'(r);
      @(negedge clk);
      chk("post_clear_rd1", bus.rd1, '0);
      chk("post_clear_busy1", bus.busy1, 1'b0);
      tick();
    end

    // Random traffic, including occasional clears.
    for (int n = 0; n < 500; n++) begin
      bus.we = ($urandom % 3) != 0;
      bus.wa = 5'($urandom);
      bus.wd = rand_vec();
      case ($urandom % 4)
        0:       bus.wmask = 16'h0000;
        1:       bus.wmask = 16'hFFFF;
        default: bus.wmask = 16'($urandom);
      endcase
      bus.rs1 = ($urandom % 2) ? bus.wa : 5'($urandom);
      bus.rs2 = 5'($urandom);
      bus.rs3 = ($urandom % 4 == 0) ? bus.wa : 5'($urandom);
      bus.rsv_valid = ($urandom % 2) != 0;
      bus.rsv_addr = ($urandom % 4 == 0) ? bus.wa : 5'($urandom);
      bus.clr_req = ($urandom % 60) == 0;
      cyc();
    end
    set_idle();
    for (int n = 0; n < 40; n++) cyc();

    // Reset in the middle of a clear.
    bus.we = 1'b1; bus.wa = 5'd20; bus.wd = fill(16'h5A5A); bus.wmask = 16'hFFFF;
    cyc();
    set_idle(); bus.clr_req = 1'b1;
    cyc();
    set_idle(); bus.rs1 = 5'd20;
    for (int k = 1; k <= 9; k++) cyc();
    @(negedge clk);
    chk("pre_reset_rd1", bus.rd1, fill(16'h5A5A));
    chk("pre_reset_clr_busy", bus.clr_busy, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midclr_reset_rd1", bus.rd1, '0);
    chk("midclr_reset_clr_busy", bus.clr_busy, 1'b0);
    chk("midclr_reset_clr_done", bus.clr_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.clr_done) done_cnt++;
      tick();
    end
    chk("midclr_no_done", 256'(done_cnt), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
